// File: rtl/irq_ctl.sv
// Eight-source interrupt controller with an NMI line, on a CPU register bus.
// Sources are synchronised, then latched per bit as edge- or level-triggered pending flags.
module irq_ctl #(
  parameter logic [15:0] BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AD,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  input  logic        WE,
  input  logic        RDY,
  output logic        hit,
  input  logic [7:0]  src,
  input  logic        nmi_in,
  output logic        IRQ,
  output logic        NMI
);

  localparam logic [1:0] REG_PEND   = 2'd0;
  localparam logic [1:0] REG_ENABLE = 2'd1;
  localparam logic [1:0] REG_MODE   = 2'd2;
  localparam logic [1:0] REG_VECTOR = 2'd3;

  // Bit 8 of each synchroniser stage carries nmi_in alongside the eight sources.
  logic [8:0] s1_reg, s2_reg, s3_reg;
  logic [7:0] pend_reg, pend_next;
  logic [7:0] enable_reg, mode_reg;
  logic       sel, wr, rd;
  logic [7:0] rise, w1c, active, vector, rdata;
  logic [2:0] vec_idx;
  logic       nmi_rise, nmi_ack, nmi_next;

  assign sel = (AD[15:2] == BASE[15:2]);
  assign wr  = sel & WE & RDY;
  assign rd  = sel & ~WE & RDY;

  assign rise     = s2_reg[7:0] & ~s3_reg[7:0];
  assign w1c      = (wr && AD[1:0] == REG_PEND) ? DI : 8'h00;
  assign nmi_rise = s2_reg[8] & ~s3_reg[8];
  assign nmi_ack  = wr && (AD[1:0] == REG_VECTOR) && DI[7];
  // A fresh NMI edge wins over an acknowledge landing on the same clock.
  assign nmi_next = nmi_rise | (NMI & ~nmi_ack);

  // Edge bits: a set beats a same-cycle clear. Level bits simply track the synchronised input.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pend
      assign pend_next[gi] = mode_reg[gi] ? (rise[gi] | (pend_reg[gi] & ~w1c[gi]))
                                          : s2_reg[gi];
    end
  endgenerate

  assign active = pend_reg & enable_reg;

  // Descending scan so the lowest-numbered active source ends up in vec_idx.
  always_comb begin
    vec_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) vec_idx = 3'(i);
    end
  end

  assign vector = {~|active, NMI, 3'b000, vec_idx};

  always_comb begin
    rdata = 8'h00;
    case (AD[1:0])
      REG_PEND:   rdata = pend_reg;
      REG_ENABLE: rdata = enable_reg;
      REG_MODE:   rdata = mode_reg;
      REG_VECTOR: rdata = vector;
      default:    rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      s1_reg     <= '0;
      s2_reg     <= '0;
      s3_reg     <= '0;
      pend_reg   <= '0;
      enable_reg <= '0;
      mode_reg   <= '0;
      IRQ        <= 1'b0;
      NMI        <= 1'b0;
      DO         <= 8'h00;
      hit        <= 1'b0;
    end else begin
      s1_reg   <= {nmi_in, src};
      s2_reg   <= s1_reg;
      s3_reg   <= s2_reg;
      pend_reg <= pend_next;
      if (wr && AD[1:0] == REG_ENABLE) enable_reg <= DI;
      if (wr && AD[1:0] == REG_MODE)   mode_reg   <= DI;
      IRQ <= |active;
      NMI <= nmi_next;
      // A stalled bus (RDY=0) leaves the read-data register untouched.
      if (RDY) begin
        if (rd) begin
          DO  <= rdata;
          hit <= 1'b1;
        end else begin
          DO  <= 8'h00;
          hit <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: directed scenarios plus a randomised run against a cycle model
// built from the register/latency rules of the controller.
module tb_irq_ctl;

  localparam logic [15:0] BASE = 16'hFE00;

  logic        clk;
  logic        RST;
  logic [15:0] AD;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        WE;
  logic        RDY;
  logic        hit;
  logic [7:0]  src;
  logic        nmi_in;
  logic        IRQ;
  logic        NMI;

  int checks   = 0;
  int failures = 0;

  irq_ctl #(.BASE(BASE)) dut (
    .clk(clk), .RST(RST), .AD(AD), .DI(DI), .DO(DO), .WE(WE), .RDY(RDY),
    .hit(hit), .src(src), .nmi_in(nmi_in), .IRQ(IRQ), .NMI(NMI)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state; pipe holds the sampled {nmi_in,src} history, newest first.
  logic [8:0] pipe[$] = '{9'h0, 9'h0, 9'h0};
  logic [7:0] m_pend = 8'h00, m_en = 8'h00, m_mode = 8'h00, m_do = 8'h00;
  logic       m_irq = 1'b0, m_nmi = 1'b0, m_hit = 1'b0;

  task automatic model_step();
    logic [8:0] s2v, s3v;
    logic [7:0] rise, act, rdv, pn;
    logic       sel, wr, rd, nrise, ack;
    int         lo;
    if (RST) begin
      m_pend = 0; m_en = 0; m_mode = 0; m_do = 0;
      m_irq = 0; m_nmi = 0; m_hit = 0;
      pipe = '{9'h0, 9'h0, 9'h0};
      return;
    end
    s2v   = pipe[1];
    s3v   = pipe[2];
    rise  = s2v[7:0] & ~s3v[7:0];
    nrise = s2v[8] & ~s3v[8];
    sel   = (AD[15:2] == BASE[15:2]);
    wr    = sel && WE && RDY;
    rd    = sel && !WE && RDY;
    act   = m_pend & m_en;
    lo    = 0;
    for (int i = 7; i >= 0; i--) if (act[i]) lo = i;
    case (AD[1:0])
      2'd0: rdv = m_pend;
      2'd1: rdv = m_en;
      2'd2: rdv = m_mode;
      default: rdv = (act == 0) ? (8'h80 | (m_nmi ? 8'h40 : 8'h00))
                                : ((m_nmi ? 8'h40 : 8'h00) | 8'(lo));
    endcase
    for (int i = 0; i < 8; i++) begin
      if (!m_mode[i])                            pn[i] = s2v[i];
      else if (rise[i])                          pn[i] = 1'b1;
      else if (wr && AD[1:0] == 2'd0 && DI[i])   pn[i] = 1'b0;
      else                                       pn[i] = m_pend[i];
    end
    ack   = wr && AD[1:0] == 2'd3 && DI[7];
    m_irq = (act != 0);
    m_nmi = nrise ? 1'b1 : (ack ? 1'b0 : m_nmi);
    if (wr && AD[1:0] == 2'd1) m_en = DI;
    if (wr && AD[1:0] == 2'd2) m_mode = DI;
    m_pend = pn;
    if (RDY) begin
      m_do  = rd ? rdv : 8'h00;
      m_hit = rd;
    end
    pipe.push_front({nmi_in, src});
    void'(pipe.pop_back());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    AD = 16'h0000; WE = 1'b0; RDY = 1'b1; DI = 8'h00;
  endtask

  task automatic bus_write(input logic [1:0] idx, input logic [7:0] data);
    AD = {BASE[15:2], idx}; WE = 1'b1; RDY = 1'b1; DI = data;
    tick();
    idle();
  endtask

  task automatic bus_read(input logic [1:0] idx);
    AD = {BASE[15:2], idx}; WE = 1'b0; RDY = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    src = 8'hFF; nmi_in = 1'b1; idle(); RST = 1'b1;
    tick();
    checks++;
    if ({IRQ, NMI, hit, DO} !== 11'h000) begin
      failures++;
      $display("FAIL reset_outputs: got IRQ=%b NMI=%b hit=%b DO=%h expected all 0", IRQ, NMI, hit, DO);
    end
    RST = 1'b0;
    tick(); tick();
    checks++;
    if (NMI !== 1'b0) begin failures++; $display("FAIL reset_nmi_edge2: got %b expected 0", NMI); end
    tick();
    checks++;
    if (NMI !== 1'b1) begin failures++; $display("FAIL reset_nmi_edge3: got %b expected 1", NMI); end
    src = 8'h00; nmi_in = 1'b0;
    bus_write(2'd3, 8'h80);
    tick(); tick(); tick();
    checks++;
    if (NMI !== 1'b0) begin failures++; $display("FAIL reset_nmi_ack: got %b expected 0", NMI); end
  endtask

  task automatic test_edge_irq();
    bus_write(2'd2, 8'h04);
    bus_write(2'd1, 8'h04);
    src = 8'h04;
    tick();
    src = 8'h00;
    tick(); tick();
    checks++;
    if (IRQ !== 1'b0) begin failures++; $display("FAIL edge_irq_edge3: got %b expected 0", IRQ); end
    tick();
    checks++;
    if (IRQ !== 1'b1) begin failures++; $display("FAIL edge_irq_edge4: got %b expected 1", IRQ); end
    bus_read(2'd3);
    checks++;
    if (DO !== 8'h02 || hit !== 1'b1) begin
      failures++; $display("FAIL edge_vector: got DO=%h hit=%b expected 02/1", DO, hit);
    end
    bus_write(2'd0, 8'h04);
    checks++;
    if (IRQ !== 1'b1) begin failures++; $display("FAIL edge_w1c_same: got %b expected 1", IRQ); end
    tick();
    checks++;
    if (IRQ !== 1'b0) begin failures++; $display("FAIL edge_w1c_next: got %b expected 0", IRQ); end
  endtask

  task automatic test_level_irq();
    bus_write(2'd2, 8'h00);
    bus_write(2'd1, 8'h81);
    src = 8'h81;
    repeat (4) tick();
    checks++;
    if (IRQ !== 1'b1) begin failures++; $display("FAIL level_irq_high: got %b expected 1", IRQ); end
    bus_read(2'd3);
    checks++;
    if (DO !== 8'h00) begin failures++; $display("FAIL level_vec_both: got %h expected 00", DO); end
    src = 8'h80;
    repeat (4) tick();
    bus_read(2'd3);
    checks++;
    if (DO !== 8'h07) begin failures++; $display("FAIL level_vec_src7: got %h expected 07", DO); end
    src = 8'h00;
    repeat (4) tick();
    bus_read(2'd3);
    checks++;
    if (DO !== 8'h80 || IRQ !== 1'b0) begin
      failures++; $display("FAIL level_vec_none: got DO=%h IRQ=%b expected 80/0", DO, IRQ);
    end
  endtask

  task automatic test_simultaneous();
    bus_write(2'd2, 8'h02);
    bus_write(2'd1, 8'h02);
    src = 8'h02;
    tick(); tick();
    bus_write(2'd0, 8'h02);
    bus_read(2'd0);
    checks++;
    if (DO !== 8'h02) begin failures++; $display("FAIL sim_set_vs_w1c: got %h expected 02", DO); end
    src = 8'h00;
    bus_write(2'd0, 8'h02);
    nmi_in = 1'b1;
    tick(); tick();
    bus_write(2'd3, 8'h80);
    checks++;
    if (NMI !== 1'b1) begin failures++; $display("FAIL sim_nmi_vs_ack: got %b expected 1", NMI); end
    bus_write(2'd3, 8'h80);
    checks++;
    if (NMI !== 1'b0) begin failures++; $display("FAIL sim_nmi_ack_later: got %b expected 0", NMI); end
    nmi_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_rdy_stall();
    bus_write(2'd1, 8'h5A);
    tick();
    AD = {BASE[15:2], 2'd1}; WE = 1'b0; RDY = 1'b0;
    tick();
    checks++;
    if (DO !== 8'h00 || hit !== 1'b0) begin
      failures++; $display("FAIL stall_read_hold: got DO=%h hit=%b expected 00/0", DO, hit);
    end
    RDY = 1'b1;
    tick();
    checks++;
    if (DO !== 8'h5A || hit !== 1'b1) begin
      failures++; $display("FAIL stall_read_go: got DO=%h hit=%b expected 5a/1", DO, hit);
    end
    WE = 1'b1; DI = 8'hFF; RDY = 1'b0;
    tick();
    checks++;
    if (DO !== 8'h5A || hit !== 1'b1) begin
      failures++; $display("FAIL stall_write_hold: got DO=%h hit=%b expected 5a/1", DO, hit);
    end
    idle();
    bus_read(2'd1);
    checks++;
    if (DO !== 8'h5A) begin failures++; $display("FAIL stall_write_ignored: got %h expected 5a", DO); end
  endtask

  task automatic test_random();
    RST = 1'b1; idle(); src = 8'h00; nmi_in = 1'b0;
    tick();
    RST = 1'b0;
    for (int n = 0; n < 600; n++) begin
      RST    = ($urandom_range(0, 199) == 0);
      src    = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      nmi_in = ($urandom_range(0, 7) == 0) ? ~nmi_in : nmi_in;
      if ($urandom_range(0, 9) < 7) AD = {BASE[15:2], 2'($urandom)};
      else                          AD = 16'($urandom);
      WE  = 1'($urandom);
      RDY = ($urandom_range(0, 4) != 0);
      DI  = 8'($urandom);
      tick();
      checks++;
      if (DO !== m_do || hit !== m_hit || IRQ !== m_irq || NMI !== m_nmi) begin
        failures++;
        $display("FAIL rand_cycle%0d: got DO=%h hit=%b IRQ=%b NMI=%b expected DO=%h hit=%b IRQ=%b NMI=%b",
                 n, DO, hit, IRQ, NMI, m_do, m_hit, m_irq, m_nmi);
      end
    end
  endtask

  initial begin
    RST = 1'b0; src = 8'h00; nmi_in = 1'b0; idle();
    test_reset();
    test_edge_irq();
    test_level_irq();
    test_simultaneous();
    test_rdy_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
